// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RISC-V
// funct3 width codes, fault codes and the request legality helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FLT_OK  = 2'b00;
  localparam logic [1:0] FLT_MIS = 2'b01;
  localparam logic [1:0] FLT_ILL = 2'b10;
  localparam logic [1:0] FLT_TO  = 2'b11;

  // Unsigned widths exist only for loads.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response and data-memory req/ack bus of the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              start;
  logic              is_store;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic [31:0]       rdata;
  logic [1:0]        fault;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  // The LSU itself.
  modport slave (
    input  start, is_store, funct3, addr, wdata, mem_ack, mem_rdata,
    output busy, done, rdata, fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  // Datapath plus memory side driving the LSU.
  modport master (
    output start, is_store, funct3, addr, wdata, mem_ack, mem_rdata,
    input  busy, done, rdata, fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: store byte enables and lane-replicated data,
// plus load lane extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (offset)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    ld_data   = mem_rdata;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        ld_data   = {{24{ld_byte[7]}}, ld_byte};
      end
      F3_H: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        ld_data   = {{16{ld_half[15]}}, ld_half};
      end
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: validates the request, runs one req/ack memory
// transaction with a timeout, and returns a registered, extended load result.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        cnt;
  logic              is_store_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       rdata_q;
  logic [1:0]        fault_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;

  logic [2:0]  f3_sel;
  logic [1:0]  off_sel;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] ld_data;

  // One lane aligner serves both phases: live request fields in IDLE for the
  // store formatting, latched fields afterwards for the load extraction.
  always_comb begin
    f3_sel  = (state == IDLE) ? bus.funct3    : f3_q;
    off_sel = (state == IDLE) ? bus.addr[1:0] : off_q;
  end

  lsu_lane_align u_align (
    .funct3    (f3_sel),
    .offset    (off_sel),
    .wdata     (bus.wdata),
    .mem_rdata (bus.mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_store_q  <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      fault_q     <= FLT_OK;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_store_q <= bus.is_store;
            f3_q       <= bus.funct3;
            off_q      <= bus.addr[1:0];
            busy_q     <= 1'b1;
            rdata_q    <= '0;
            fault_q    <= FLT_OK;
            cnt        <= '0;
            if (!f3_legal(bus.is_store, bus.funct3)) begin
              state   <= RESP;
              done_q  <= 1'b1;
              fault_q <= FLT_ILL;
            end else if (f3_misaligned(bus.funct3, bus.addr[1:0])) begin
              state   <= RESP;
              done_q  <= 1'b1;
              fault_q <= FLT_MIS;
            end else begin
              state       <= ACCESS;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.is_store;
              mem_addr_q  <= bus.addr[ADDR_W+1:2];
              mem_be_q    <= bus.is_store ? be : 4'b1111;
              mem_wdata_q <= bus.is_store ? wdata_rep : '0;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_ack || cnt == TO_LAST) begin
            state       <= RESP;
            done_q      <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            // An ack coinciding with the last allowed cycle still completes.
            if (bus.mem_ack) begin
              rdata_q <= is_store_q ? '0 : ld_data;
              fault_q <= FLT_OK;
            end else begin
              rdata_q <= '0;
              fault_q <= FLT_TO;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.fault     = fault_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
